// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : sequencer state encoding (IDLE, RUN, DONE)
//   cnt_width : width of a counter able to index WIDTH bit positions
// ---------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter that walks bit positions 0..w-1 needs clog2(w) bits;
    // clamped to 1 so a degenerate width still yields a legal vector.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// 1-bit combinational full-subtractor cell: diff = a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   diff : difference bit
//   bout : borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;

    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH), LSB
// first, one bit per clock, with valid/ready handshakes on both sides.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands a, b, bin are valid
//   in_ready   : block can accept operands (IDLE)
//   a, b       : minuend / subtrahend, WIDTH bits
//   bin        : borrow-in for chaining
//   out_valid  : result valid (DONE)
//   out_ready  : consumer accepts the result
//   diff       : result, WIDTH bits
//   borrow_out : unsigned borrow out of the MSB
//   ovf        : signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN defined)
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (cnt == LAST_BIT);

    // The single arithmetic cell, fed from the operand LSBs and the borrow flop.
    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .diff (cell_d),
        .bout (cell_bo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. DONE returns to IDLE rather than
    // accepting directly, so a new operand waits one cycle for in_ready.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Serial datapath: operands shift right, result bits enter at the MSB so
    // that after WIDTH steps the LSB computed first sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {cell_d, res[WIDTH-1:1]};
            br   <= cell_bo;
            cnt  <= cnt + CW'(1);
        end
    end

    assign diff       = res;
    assign borrow_out = br;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Signed overflow: during the last step br is the borrow into the MSB
    // stage and cell_bo the borrow out of it; they differ on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf <= br ^ cell_bo;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus
// randomized operands compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ua;
        int ub;
        int sa;
        int sb;
        int ur;
        int sr;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        ur = ua - ub - int'(bi);
        sr = sa - sb - int'(bi);
        d  = W'((ur + (1 << (W + 1))) % (1 << W));
        bo = (ua < ub + int'(bi));
        ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    endtask

    // Wait (bounded) for in_ready, then present operands for one accept edge.
    task automatic acceptOperands(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic bi);
        int waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'(1));
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom);
        checkOutput("in_ready_in_run", 64'(in_ready), 64'(0));
    endtask

    // Accept operands and check out_valid rises exactly W edges later.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi);
        acceptOperands(av, bv, bi);
        for (int i = 1; i <= W; i++) begin
            tick();
            if (i == W - 1) begin
                checkOutput("out_valid_early", 64'(out_valid), 64'(0));
            end
        end
        checkOutput("latency_out_valid", 64'(out_valid), 64'(1));
    endtask

    // Compare the presented result against the model.
    task automatic expectResult(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic bi);
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        model(av, bv, bi, d, bo, ov);
        checkOutput("diff", 64'(diff), 64'(d));
        checkOutput("borrow_out", 64'(borrow_out), 64'(bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("ovf", 64'(ovf), 64'(ov));
`else
        if (ov && 1'b0) begin
            $display("[TB] unreachable");
        end
`endif
    endtask

    // Hold the result for 'hold' cycles, then consume it.
    task automatic drainResult(input int hold);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_after_drain", 64'(out_valid), 64'(0));
        checkOutput("in_ready_after_drain", 64'(in_ready), 64'(1));
    endtask

    task automatic runOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         input int hold);
        applyStimulus(av, bv, bi);
        expectResult(av, bv, bi);
        drainResult(hold);
    endtask

    initial begin
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;

        // Reset state.
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_diff", 64'(diff), 64'(0));
        checkOutput("reset_borrow", 64'(borrow_out), 64'(0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checkOutput("reset_ovf", 64'(ovf), 64'(0));
`endif
        rst_n = 1'b1;
        tick();

        // Directed cases: nominal, underflow, borrow-in.
        runOp(8'h5A, 8'h23, 1'b0, 0);
        runOp(8'h00, 8'h01, 1'b0, 0);
        runOp(8'h10, 8'h10, 1'b1, 2);

        // Backpressure with competing operands on the input side.
        applyStimulus(8'hC3, 8'h4E, 1'b0);
        model(8'hC3, 8'h4E, 1'b0, ed, eb, eo);
        out_ready = 1'b0;
        a         = 8'h01;
        b         = 8'h01;
        bin       = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            checkOutput("bp_diff", 64'(diff), 64'(ed));
            checkOutput("bp_borrow", 64'(borrow_out), 64'(eb));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_in_ready_next", 64'(in_ready), 64'(1));
        tick();
        tick();
        checkOutput("bp_no_capture", 64'(out_valid), 64'(0));
        checkOutput("bp_still_idle", 64'(in_ready), 64'(1));

        // Reset in the middle of RUN after three bits.
        acceptOperands(8'hA7, 8'h39, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_mid_diff", 64'(diff), 64'(0));
        checkOutput("rst_mid_borrow", 64'(borrow_out), 64'(0));
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'(1));
        #10;
        rst_n = 1'b1;
        tick();
        checkOutput("rst_rel_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_rel_out_valid", 64'(out_valid), 64'(0));
        runOp(8'h05, 8'h03, 1'b0, 0);

        // Signed overflow corner cases (ovf checked when the feature exists).
        runOp(8'h80, 8'h01, 1'b0, 0);
        runOp(8'h7F, 8'hFF, 1'b0, 0);
        runOp(8'hFF, 8'hFF, 1'b1, 1);
        runOp(8'h00, 8'h00, 1'b0, 0);

        // Randomized operands with random consumer delay.
        for (int n = 0; n < 40; n++) begin
            runOp(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Built around a 1-bit full-subtractor cell plus a borrow flop; it is the subtraction counterpart of the team's 1-bit full-adder cell.
- Targets area-constrained datapaths where multi-cycle latency is acceptable.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned or two's complement).
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in, for chaining.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- borrow_out  output  1  unsigned borrow out of the MSB.

Behaviour:
- Interface: single clock clk; asynchronous active-low reset rst_n.
- Reset (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, bit counter=0, borrow flop=0, operand shift registers=0.
- FSM, IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a, b into shift registers, load bin into the borrow flop, clear the counter, go to RUN.
- FSM, RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the cell takes a_sh[0], b_sh[0] and the borrow flop, producing d = a^b^br and bo = (~a&b) | (~(a^b)&br).
  - d shifts into the MSB of the result register (right shift).
  - bo updates the borrow flop; the operand registers shift right.
  - Counter increments. When it reaches WIDTH-1 that cycle processes the last bit, and the FSM goes to DONE.
- FSM, DONE:
  - out_valid=1; diff = result register; borrow_out = borrow flop.
  - On out_ready go to IDLE.
  - No new operand is accepted in the same cycle; in_ready rises the next cycle.
- Latency: acceptance at edge t0 gives out_valid=1 after edge t0+WIDTH (RUN lasts exactly WIDTH cycles).
- Throughput: one result per WIDTH+2 cycles with out_ready tied high.
- Backpressure: in DONE with out_ready=0, diff, borrow_out and out_valid hold stable indefinitely.
- in_valid while in RUN or DONE is ignored (in_ready=0). The producer must hold its data until handshake.
- diff and borrow_out outside DONE show internal register contents; they are only meaningful when out_valid=1.
- Wrap-around: the result is modulo 2^WIDTH. borrow_out=1 iff the unsigned value a < b+bin.
- Reset mid-RUN or mid-DONE discards the operation. After rst_n deasserts the block sits in IDLE with in_ready=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow, equal to the borrow into the MSB stage XOR borrow_out.
  - Registered in the final RUN cycle; valid with out_valid.
  - Resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package arith_pkg:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter-width helper constant/function (clog2 of WIDTH).
- Sub-module full_subtractor:
  - 1-bit combinational cell (a, b, bin -> diff, bout), instantiated once.
  - Reusable elsewhere, mirroring the existing full-adder cell.

Test Plan:
- Nominal: WIDTH=8, a=0x5A, b=0x23, bin=0 -> diff=0x37, borrow_out=0; out_valid rises exactly 8 cycles after the accept edge.
- Underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1.
- Borrow-in: a=0x10, b=0x10, bin=1 -> diff=0xFF, borrow_out=1.
- Backpressure and ignore:
  - Hold out_ready=0 for 5 cycles in DONE, driving in_valid=1 with a=0x01, b=0x01 meanwhile.
  - Result stays stable, in_ready=0 throughout, and the new operands are not taken.
  - After out_ready, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 after 3 bits processed -> out_valid=0, diff=0, borrow_out=0, in_ready=1 immediately and after release.
  - The next operation a=0x05, b=0x03 gives diff=0x02.
- With SERIAL_SUBTRACTOR_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
